pattern_gen_720p: RTL and testbench
===================================

PATTERN_GEN_720P -- requirements
Module: pattern_gen_720p

Interface
REQ-001 SHALL have parameter CORDW, default 16, width of screen coordinates.
REQ-002 SHALL have parameter COLOR_WIDTH, default 8, bits per colour channel.
REQ-003 SHALL have parameter H_RES, default 1280, active pixels per line.
REQ-004 SHALL have port clk_pix  in  1  pixel clock; the block has this one clock only.
REQ-005 SHALL have port rst  in  1  reset, synchronous to clk_pix, active-high.
REQ-006 SHALL have ports hsync_i, vsync_i, de_i  in  1 each  timing strobes from the display timing generator.
REQ-007 SHALL have port frame_i  in  1  one-cycle pulse at the start of a frame.
REQ-008 SHALL have ports sx_i, sy_i  in  CORDW each  current screen position.
REQ-009 SHALL have port mode_i  in  2  requested pattern: 0 noise, 1 colour bars, 2 checkerboard, 3 gradient.
REQ-010 SHALL have ports hsync_o, vsync_o, de_o  out  1 each  timing strobes delayed to align with the pixel outputs.
REQ-011 SHALL have ports red_o, green_o, blue_o  out  COLOR_WIDTH each  pixel data for the TMDS encoders.

Function
REQ-012 SHALL register every output, with a fixed latency of 2 clk_pix cycles from inputs to outputs for strobes and pixel data alike.
REQ-013 SHALL latch mode_i into an active-mode register only in a cycle where frame_i=1; mode_i changes mid-frame have no effect until the next frame_i.
REQ-014 SHALL drive red_o/green_o/blue_o = 0 whenever the aligned de_o = 0.
REQ-015 Noise mode: lfsr output r (8 bits), advancing every cycle; red=r, green={r[3:0],r[7:4]}, blue=~r.
REQ-016 Colour bars: bar index = sx_i / (H_RES/8), clamped to 7; colours in order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
REQ-017 Checkerboard: white when sx_i[5] XOR sy_i[5] = 0, black otherwise (32x32 squares).
REQ-018 Gradient: red = sx_i[7:0] + offset (mod 256), green = sy_i[7:0], blue = offset.
REQ-019 offset SHALL be an 8-bit frame counter incrementing by 1 on each frame_i pulse and wrapping 255 -> 0.
REQ-020 When frame_i and a mode change coincide, the new mode SHALL apply to the pixel presented in that same cycle.
REQ-021 SHALL leave pixel values for COLOR_WIDTH > 8 zero-extended in the LSBs, i.e. the 8-bit value occupies the MSBs.

Reset
REQ-022 While rst=1, all outputs SHALL be 0 on the next clock edge and both pipeline stages SHALL be cleared.
REQ-023 Reset SHALL set the active mode to 0, the offset to 0 and the lfsr to its seed.
REQ-024 Reset asserted mid-frame SHALL take effect on the next edge; after release, outputs follow inputs with 2-cycle latency and mode 0 holds until the next frame_i.

Configuration
REQ-025 With macro PATTERN_SCROLL_EN defined, the offset SHALL update per REQ-019.
REQ-026 Without PATTERN_SCROLL_EN, the offset SHALL be held at 0, the gradient SHALL be static, and no counter logic SHALL be synthesised.

Structure
REQ-027 A shared package video_pkg SHALL hold the mode encodings, the 8-entry bar colour table and the 720p resolution constants.
REQ-028 The noise source SHALL be one instance of the existing lfsr module (WIDTH 10, SEED 10'h3f7, next_i tied high).

Verification
REQ-029 Latency: de_i rises at cycle N -> de_o rises at cycle N+2; the same holds for hsync_i and vsync_i.
REQ-030 Bars: mode 1 latched, sx_i=0 -> FFFFFF; sx_i=160 -> FFFF00; sx_i=1279 -> 000000.
REQ-031 Checkerboard: mode 2, (sx,sy)=(0,0) -> FFFFFF; (32,0) -> 000000; (32,32) -> FFFFFF.
REQ-032 Mode latch: mode_i switches 1->2 mid-frame -> bars continue; next frame_i -> checkerboard.
REQ-033 Gradient wrap with PATTERN_SCROLL_EN: after 256 frame_i pulses the offset returns to 0; at (sx,sy)=(10,5) with offset 250 -> red=04, green=05, blue=FA.
REQ-034 Reset: rst asserted mid-line -> all outputs 0 next cycle; the lfsr sequence restarts from the seed after release.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video definitions: pattern mode encodings, colour-bar table and
// 720p timing constants used by the pattern generator.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_NOISE    = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_GRADIENT = 2'd3
    } mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    typedef struct packed {
        logic  hsync;
        logic  vsync;
        logic  de;
        rgb8_t rgb;
    } pix_t;

    localparam int H_RES_720P   = 1280;
    localparam int V_RES_720P   = 720;
    localparam int H_TOTAL_720P = 1650;
    localparam int V_TOTAL_720P = 750;

    localparam int              LFSR_WIDTH = 10;
    localparam logic [9:0]      LFSR_SEED  = 10'h3f7;
    localparam logic [9:0]      LFSR_TAPS  = 10'h240;

    // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [23:0] BAR_TABLE [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/lfsr.sv
// Fibonacci LFSR that shifts left one bit per enabled cycle; feedback is
// the XOR of the state bits selected by TAPS.
module lfsr #(
    parameter int               WIDTH = 10,
    parameter logic [WIDTH-1:0] SEED  = 10'h3f7,
    parameter logic [WIDTH-1:0] TAPS  = 10'h240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             next_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (next_i) begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign value_o = state_q;

endmodule

// File: rtl/pattern_gen_720p_color.sv
// Combinational pixel colour for the selected test pattern at one screen
// position; the caller supplies the noise byte and the gradient offset.
module pattern_gen_720p_color
    import video_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int H_RES = 1280
) (
    input  mode_e            mode_i,
    input  logic [CORDW-1:0] sx_i,
    input  logic [CORDW-1:0] sy_i,
    input  logic [7:0]       offset_i,
    input  logic [7:0]       noise_i,
    output rgb8_t            rgb_o
);

    localparam int BAR_W = H_RES / 8;

    logic [CORDW-1:0] bar_q;
    logic [2:0]       bar_idx;
    logic             unused_sy;

    assign unused_sy = ^sy_i[CORDW-1:8];

    always_comb begin
        rgb_o   = '0;
        bar_q   = sx_i / CORDW'(BAR_W);
        bar_idx = (bar_q > CORDW'(7)) ? 3'd7 : bar_q[2:0];
        case (mode_i)
            MODE_NOISE: begin
                rgb_o.r = noise_i;
                rgb_o.g = {noise_i[3:0], noise_i[7:4]};
                rgb_o.b = ~noise_i;
            end
            MODE_BARS: begin
                rgb_o = rgb8_t'(BAR_TABLE[bar_idx]);
            end
            MODE_CHECKER: begin
                rgb_o = (sx_i[5] ^ sy_i[5]) ? 24'h000000 : 24'hFFFFFF;
            end
            MODE_GRADIENT: begin
                rgb_o.r = sx_i[7:0] + offset_i;
                rgb_o.g = sy_i[7:0];
                rgb_o.b = offset_i;
            end
            default: rgb_o = '0;
        endcase
    end

endmodule

// File: rtl/pattern_gen_720p.sv
// 720p test-pattern generator with a two-stage pipeline aligning strobes and
// pixel data. Define PATTERN_SCROLL_EN to make the gradient scroll per frame.
module pattern_gen_720p
    import video_pkg::*;
#(
    parameter int CORDW       = 16,
    parameter int COLOR_WIDTH = 8,
    parameter int H_RES       = 1280
) (
    input  logic                   clk_pix,
    input  logic                   rst,
    input  logic                   hsync_i,
    input  logic                   vsync_i,
    input  logic                   de_i,
    input  logic                   frame_i,
    input  logic [CORDW-1:0]       sx_i,
    input  logic [CORDW-1:0]       sy_i,
    input  logic [1:0]             mode_i,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   de_o,
    output logic [COLOR_WIDTH-1:0] red_o,
    output logic [COLOR_WIDTH-1:0] green_o,
    output logic [COLOR_WIDTH-1:0] blue_o
);

    mode_e                 mode_q, mode_d;
    logic [7:0]            offset;
    logic [LFSR_WIDTH-1:0] lfsr_val;
    logic                  unused_lfsr;
    rgb8_t                 rgb_calc;
    pix_t                  s1_q, s1_d, s2_q, s2_d;

    function automatic logic [COLOR_WIDTH-1:0] widen(input logic [7:0] v);
        return COLOR_WIDTH'(v) << (COLOR_WIDTH - 8);
    endfunction

    // mode_d also drives the colour logic so a mode change on the frame
    // pulse applies to the pixel presented in that same cycle.
    always_comb begin
        mode_d = mode_q;
        if (frame_i) begin
            mode_d = mode_e'(mode_i);
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            mode_q <= MODE_NOISE;
        end else begin
            mode_q <= mode_d;
        end
    end

`ifdef PATTERN_SCROLL_EN
    logic [7:0] offset_q, offset_d;

    always_comb begin
        offset_d = offset_q;
        if (frame_i) begin
            offset_d = offset_q + 8'd1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end

    assign offset = offset_q;
`else
    assign offset = 8'h00;
`endif

    lfsr #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk_pix),
        .rst     (rst),
        .next_i  (1'b1),
        .value_o (lfsr_val)
    );

    assign unused_lfsr = ^lfsr_val[LFSR_WIDTH-1:8];

    pattern_gen_720p_color #(
        .CORDW (CORDW),
        .H_RES (H_RES)
    ) u_color (
        .mode_i   (mode_d),
        .sx_i     (sx_i),
        .sy_i     (sy_i),
        .offset_i (offset),
        .noise_i  (lfsr_val[7:0]),
        .rgb_o    (rgb_calc)
    );

    always_comb begin
        s1_d.hsync = hsync_i;
        s1_d.vsync = vsync_i;
        s1_d.de    = de_i;
        s1_d.rgb   = rgb_calc;
        s2_d       = s1_q;
        if (!s1_q.de) begin
            s2_d.rgb = '0;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign hsync_o = s2_q.hsync;
    assign vsync_o = s2_q.vsync;
    assign de_o    = s2_q.de;
    assign red_o   = widen(s2_q.rgb.r);
    assign green_o = widen(s2_q.rgb.g);
    assign blue_o  = widen(s2_q.rgb.b);

endmodule

// File: tb/tb_pattern_gen_720p.sv
// Bench for pattern_gen_720p: directed scenario tasks plus a randomized run
// compared cycle by cycle against a behavioural pattern model.
module tb_pattern_gen_720p;

    localparam int HR = 1280;

    logic        clk_pix = 1'b0;
    logic        rst;
    logic        hsync_i, vsync_i, de_i, frame_i;
    logic [15:0] sx_i, sy_i;
    logic [1:0]  mode_i;
    logic        hsync_o, vsync_o, de_o;
    logic [7:0]  red_o, green_o, blue_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_pix = ~clk_pix;

    pattern_gen_720p #(
        .CORDW       (16),
        .COLOR_WIDTH (8),
        .H_RES       (HR)
    ) dut (
        .clk_pix (clk_pix),
        .rst     (rst),
        .hsync_i (hsync_i),
        .vsync_i (vsync_i),
        .de_i    (de_i),
        .frame_i (frame_i),
        .sx_i    (sx_i),
        .sy_i    (sy_i),
        .mode_i  (mode_i),
        .hsync_o (hsync_o),
        .vsync_o (vsync_o),
        .de_o    (de_o),
        .red_o   (red_o),
        .green_o (green_o),
        .blue_o  (blue_o)
    );

    // Reference model: pattern rules computed from screen arithmetic.
    function automatic logic [23:0] ref_pixel(input int mode, input int sx, input int sy,
                                              input int off, input int lf);
        logic [23:0] bars [8];
        logic [7:0]  r;
        int          idx;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        r = lf[7:0];
        case (mode)
            0: return {r, r[3:0], r[7:4], ~r};
            1: begin
                idx = sx / (HR / 8);
                if (idx > 7) idx = 7;
                return bars[idx];
            end
            2: return ((((sx / 32) + (sy / 32)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            default: return {8'((sx + off) % 256), 8'(sy % 256), 8'(off)};
        endcase
    endfunction

    // Polynomial x^10 + x^7 + 1, new bit enters at the bottom.
    function automatic int lfsr_adv(input int s);
        int fb;
        fb = ((s >> 9) ^ (s >> 6)) & 1;
        return ((s << 1) | fb) & 'h3FF;
    endfunction

    int          m_mode = 0;
    int          m_off  = 0;
    int          m_lfsr = 'h3f7;
    logic [26:0] m_s1   = '0;
    logic [26:0] m_exp  = '0;

    always @(posedge clk_pix) begin
        if (rst) begin
            m_mode <= 0;
            m_off  <= 0;
            m_lfsr <= 'h3f7;
            m_s1   <= '0;
            m_exp  <= '0;
        end else begin
            m_s1  <= {hsync_i, vsync_i, de_i,
                      ref_pixel(frame_i ? int'(mode_i) : m_mode, int'(sx_i), int'(sy_i), m_off, m_lfsr)};
            m_exp <= m_s1[24] ? m_s1 : {m_s1[26:24], 24'h000000};
            if (frame_i) begin
                m_mode <= int'(mode_i);
`ifdef PATTERN_SCROLL_EN
                m_off  <= (m_off + 1) % 256;
`endif
            end
            m_lfsr <= lfsr_adv(m_lfsr);
        end
    end

    task automatic tick();
        @(posedge clk_pix);
        @(negedge clk_pix);
    endtask

    task automatic idle_inputs();
        hsync_i = 1'b0; vsync_i = 1'b0; de_i = 1'b0; frame_i = 1'b0;
        sx_i = '0; sy_i = '0; mode_i = 2'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic latch_mode(input logic [1:0] m);
        mode_i  = m;
        frame_i = 1'b1;
        tick();
        frame_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hsync_i = 1'b1; vsync_i = 1'b1; de_i = 1'b1; sx_i = 16'd100; sy_i = 16'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({hsync_o, vsync_o, de_o, red_o, green_o, blue_o} !== 27'd0)
                $display("FAIL reset_outputs cyc=%0d got=%h want=0", i,
                         {hsync_o, vsync_o, de_o, red_o, green_o, blue_o});
            else n_pass++;
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_latency();
        logic [2:0] want [4];
        want = '{3'b000, 3'b111, 3'b111, 3'b000};
        do_reset();
        tick(); tick();
        hsync_i = 1'b1; vsync_i = 1'b1; de_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                hsync_i = 1'b0; vsync_i = 1'b0; de_i = 1'b0;
            end
            tick();
            n_checks++;
            if ({hsync_o, vsync_o, de_o} !== want[i])
                $display("FAIL latency step=%0d got=%b want=%b", i, {hsync_o, vsync_o, de_o}, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_bars();
        int          xs   [6];
        logic        des  [6];
        logic [23:0] want [6];
        xs   = '{0, 160, 1279, 800, 1000, 0};
        des  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        want = '{24'hFFFFFF, 24'hFFFF00, 24'h000000, 24'hFF0000, 24'h0000FF, 24'h000000};
        do_reset();
        latch_mode(2'd1);
        for (int i = 0; i < 6; i++) begin
            sx_i = 16'(xs[i]); de_i = des[i];
            tick(); tick();
            n_checks++;
            if ({red_o, green_o, blue_o} !== want[i])
                $display("FAIL bars sx=%0d de=%b got=%h want=%h", xs[i], des[i],
                         {red_o, green_o, blue_o}, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_checker();
        int          xs   [5];
        int          ys   [5];
        logic [23:0] want [5];
        xs   = '{0, 32, 32, 0, 100};
        ys   = '{0, 0, 32, 33, 70};
        want = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000};
        do_reset();
        latch_mode(2'd2);
        de_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sx_i = 16'(xs[i]); sy_i = 16'(ys[i]);
            tick(); tick();
            n_checks++;
            if ({red_o, green_o, blue_o} !== want[i])
                $display("FAIL checker xy=%0d,%0d got=%h want=%h", xs[i], ys[i],
                         {red_o, green_o, blue_o}, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mode_latch();
        do_reset();
        latch_mode(2'd1);
        de_i = 1'b1; sx_i = 16'd32; sy_i = 16'd0;
        mode_i = 2'd2;
        tick(); tick();
        n_checks++;
        if ({red_o, green_o, blue_o} !== 24'hFFFFFF)
            $display("FAIL latch_midframe got=%h want=FFFFFF", {red_o, green_o, blue_o});
        else n_pass++;
        frame_i = 1'b1;
        tick();
        frame_i = 1'b0;
        tick();
        n_checks++;
        if ({red_o, green_o, blue_o} !== 24'h000000)
            $display("FAIL latch_same_cycle got=%h want=000000", {red_o, green_o, blue_o});
        else n_pass++;
        mode_i = 2'd1;
        tick(); tick();
        n_checks++;
        if ({red_o, green_o, blue_o} !== 24'h000000)
            $display("FAIL latch_hold got=%h want=000000", {red_o, green_o, blue_o});
        else n_pass++;
    endtask

    task automatic test_gradient();
        logic [23:0] want_250, want_256;
`ifdef PATTERN_SCROLL_EN
        want_250 = 24'h0405FA;
`else
        want_250 = 24'h0A0500;
`endif
        want_256 = 24'h0A0500;
        do_reset();
        mode_i = 2'd3;
        for (int i = 0; i < 250; i++) begin
            frame_i = 1'b1; tick();
            frame_i = 1'b0; tick();
        end
        de_i = 1'b1; sx_i = 16'd10; sy_i = 16'd5;
        tick(); tick();
        n_checks++;
        if ({red_o, green_o, blue_o} !== want_250)
            $display("FAIL gradient_250 got=%h want=%h", {red_o, green_o, blue_o}, want_250);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            frame_i = 1'b1; tick();
            frame_i = 1'b0; tick();
        end
        tick();
        n_checks++;
        if ({red_o, green_o, blue_o} !== want_256)
            $display("FAIL gradient_wrap got=%h want=%h", {red_o, green_o, blue_o}, want_256);
        else n_pass++;
    endtask

    task automatic test_noise_reset();
        do_reset();
        de_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sx_i = 16'($urandom_range(0, 1279));
            tick();
            n_checks++;
            if ({hsync_o, vsync_o, de_o, red_o, green_o, blue_o} !== m_exp)
                $display("FAIL noise cyc=%0d got=%h want=%h", i,
                         {hsync_o, vsync_o, de_o, red_o, green_o, blue_o}, m_exp);
            else n_pass++;
        end
        hsync_i = 1'b1;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({hsync_o, vsync_o, de_o, red_o, green_o, blue_o} !== 27'd0)
            $display("FAIL reset_midline got=%h want=0", {hsync_o, vsync_o, de_o, red_o, green_o, blue_o});
        else n_pass++;
        rst = 1'b0;
        hsync_i = 1'b0;
        tick(); tick();
        n_checks++;
        if ({red_o, green_o, blue_o} !== 24'hF77F08)
            $display("FAIL noise_seed got=%h want=F77F08", {red_o, green_o, blue_o});
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            hsync_i = 1'($urandom_range(0, 1));
            vsync_i = 1'($urandom_range(0, 1));
            de_i    = ($urandom_range(0, 3) != 0);
            frame_i = ($urandom_range(0, 39) == 0);
            mode_i  = 2'($urandom_range(0, 3));
            sx_i    = 16'($urandom_range(0, 1400));
            sy_i    = 16'($urandom_range(0, 749));
            tick();
            n_checks++;
            if ({hsync_o, vsync_o, de_o, red_o, green_o, blue_o} !== m_exp)
                $display("FAIL random cyc=%0d got=%h want=%h", i,
                         {hsync_o, vsync_o, de_o, red_o, green_o, blue_o}, m_exp);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_latency();
        test_bars();
        test_checker();
        test_mode_latch();
        test_gradient();
        test_noise_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
